cmd_tag_arbiter: RTL and testbench

- Shares the single AFU command port among NUM_REQ compute-unit requesters, nominally 8 read CUs plus 8 write CUs.
- Grants one request per cycle using round-robin priority.
- Stamps each granted command with a free tag from a pool of TAG_COUNT-1 tags; tag 0 is never issued because it is INVALID_TAG.
- Returns tags to the pool on response and reports which CU owned each responded tag. Sits between the CU-control request FIFOs and the AFU command buffer.

---
 rtl/cmd_tag_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_cmd_tag_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_tag_arbiter.sv
// rtl/cmd_tag_arbiter.sv - round-robin command arbiter with tag allocation and response owner lookup
//
// Shares one AFU command port among NUM_REQ compute-unit requesters. Each
// granted command is stamped with the lowest free tag (1..TAG_COUNT-1, tag 0
// is INVALID_TAG). Responses return tags to the pool and report the owning CU.
//
// Ports:
//   clock, rstn               clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       per-requester handshake, req_ready is a one-hot grant
//   req_addr/size/cu_id       flattened per-requester command fields
//   cmd_valid/cmd_ready       registered command output handshake
//   cmd_tag/addr/size/cu_id   issued command fields
//   rsp_valid/rsp_tag         returned tag
//   rsp_cu_valid/rsp_cu_id    owner of the returned tag, one cycle after rsp_valid
//   tags_outstanding          number of allocated tags
//   tag_error                 sticky: a free tag or tag 0 was returned

module cmd_tag_arbiter #(
    parameter int NUM_REQ     = 16,
    parameter int TAG_COUNT   = 256,
    parameter int TAG_W       = $clog2(TAG_COUNT),
    parameter int CU_ID_RANGE = 8,
    parameter int ADDR_W      = 64,
    parameter int SIZE_W      = 12
) (
    input  logic                           clock,
    input  logic                           rstn,

    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*SIZE_W-1:0]      req_size,
    input  logic [NUM_REQ*CU_ID_RANGE-1:0] req_cu_id,

    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [TAG_W-1:0]               cmd_tag,
    output logic [ADDR_W-1:0]              cmd_addr,
    output logic [SIZE_W-1:0]              cmd_size,
    output logic [CU_ID_RANGE-1:0]         cmd_cu_id,

    input  logic                           rsp_valid,
    input  logic [TAG_W-1:0]               rsp_tag,
    output logic                           rsp_cu_valid,
    output logic [CU_ID_RANGE-1:0]         rsp_cu_id,

    output logic [TAG_W:0]                 tags_outstanding,
    output logic                           tag_error
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Tag 0 is never free so it can never be handed out.
    localparam logic [TAG_COUNT-1:0] FREE_INIT = {{(TAG_COUNT-1){1'b1}}, 1'b0};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   cmd_valid_q, cmd_valid_d;
    logic [TAG_W-1:0]       cmd_tag_q, cmd_tag_d;
    logic [ADDR_W-1:0]      cmd_addr_q, cmd_addr_d;
    logic [SIZE_W-1:0]      cmd_size_q, cmd_size_d;
    logic [CU_ID_RANGE-1:0] cmd_cu_id_q, cmd_cu_id_d;

    logic [TAG_COUNT-1:0]   free_q, free_d;
    logic [TAG_W:0]         outstanding_q, outstanding_d;
    logic [RR_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic                   rsp_cu_valid_q, rsp_cu_valid_d;
    logic [CU_ID_RANGE-1:0] rsp_cu_id_q, rsp_cu_id_d;
    logic                   tag_error_q, tag_error_d;

    // Owner table needs no reset: an entry is only read for allocated tags.
    logic [CU_ID_RANGE-1:0] owner_mem [TAG_COUNT];

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    function automatic logic [RR_W-1:0] wrap_idx(input logic [RR_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return RR_W'(s);
    endfunction

    logic            found_req;
    logic [RR_W-1:0] win_idx;

    // Iterating downward leaves the nearest requester at/after rr_ptr as winner.
    always_comb begin
        found_req = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_idx(rr_ptr_q, i)]) begin
                found_req = 1'b1;
                win_idx   = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Lowest free tag; the pool is read as registered, so a tag freed this
    // cycle is not reallocated until the following cycle.
    // ------------------------------------------------------------------
    logic             found_free;
    logic [TAG_W-1:0] alloc_tag;

    always_comb begin
        found_free = 1'b0;
        alloc_tag  = '0;
        for (int t = TAG_COUNT - 1; t >= 1; t--) begin
            if (free_q[t]) begin
                found_free = 1'b1;
                alloc_tag  = TAG_W'(t);
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    logic                   can_issue;
    logic                   grant;
    logic [CU_ID_RANGE-1:0] win_cu_id;
    logic                   rsp_tag_ok;

    assign can_issue  = !cmd_valid_q || cmd_ready;
    // Gating with rstn keeps requesters from being consumed while held in reset.
    assign grant      = rstn && can_issue && found_free && found_req;
    assign win_cu_id  = req_cu_id[win_idx*CU_ID_RANGE +: CU_ID_RANGE];
    assign rsp_tag_ok = rsp_valid && (rsp_tag != '0) && !free_q[rsp_tag];

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        cmd_valid_d    = cmd_valid_q;
        cmd_tag_d      = cmd_tag_q;
        cmd_addr_d     = cmd_addr_q;
        cmd_size_d     = cmd_size_q;
        cmd_cu_id_d    = cmd_cu_id_q;
        free_d         = free_q;
        outstanding_d  = outstanding_q;
        rr_ptr_d       = rr_ptr_q;
        rsp_cu_valid_d = rsp_valid;
        rsp_cu_id_d    = rsp_cu_id_q;
        tag_error_d    = tag_error_q;

        if (grant) begin
            cmd_valid_d = 1'b1;
            cmd_tag_d   = alloc_tag;
            cmd_addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
            cmd_size_d  = req_size[win_idx*SIZE_W +: SIZE_W];
            cmd_cu_id_d = win_cu_id;
            free_d[alloc_tag] = 1'b0;
            rr_ptr_d    = (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        if (rsp_valid) begin
            if (rsp_tag_ok) begin
                free_d[rsp_tag] = 1'b1;
                rsp_cu_id_d     = owner_mem[rsp_tag];
            end else begin
                rsp_cu_id_d = '0;
                tag_error_d = 1'b1;
            end
        end

        // The grant tag is always distinct from rsp_tag (one is free, one is not).
        case ({grant, rsp_tag_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            cmd_valid_q    <= 1'b0;
            cmd_tag_q      <= '0;
            cmd_addr_q     <= '0;
            cmd_size_q     <= '0;
            cmd_cu_id_q    <= '0;
            free_q         <= FREE_INIT;
            outstanding_q  <= '0;
            rr_ptr_q       <= '0;
            rsp_cu_valid_q <= 1'b0;
            rsp_cu_id_q    <= '0;
            tag_error_q    <= 1'b0;
        end else begin
            cmd_valid_q    <= cmd_valid_d;
            cmd_tag_q      <= cmd_tag_d;
            cmd_addr_q     <= cmd_addr_d;
            cmd_size_q     <= cmd_size_d;
            cmd_cu_id_q    <= cmd_cu_id_d;
            free_q         <= free_d;
            outstanding_q  <= outstanding_d;
            rr_ptr_q       <= rr_ptr_d;
            rsp_cu_valid_q <= rsp_cu_valid_d;
            rsp_cu_id_q    <= rsp_cu_id_d;
            tag_error_q    <= tag_error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (grant) begin
            owner_mem[alloc_tag] <= win_cu_id;
        end
    end

    assign cmd_valid        = cmd_valid_q;
    assign cmd_tag          = cmd_tag_q;
    assign cmd_addr         = cmd_addr_q;
    assign cmd_size         = cmd_size_q;
    assign cmd_cu_id        = cmd_cu_id_q;
    assign rsp_cu_valid     = rsp_cu_valid_q;
    assign rsp_cu_id        = rsp_cu_id_q;
    assign tags_outstanding = outstanding_q;
    assign tag_error        = tag_error_q;

endmodule

// File: tb/tb_cmd_tag_arbiter.sv
// tb/tb_cmd_tag_arbiter.sv - directed table-driven bench for cmd_tag_arbiter
module tb_cmd_tag_arbiter;

    localparam int NUM_REQ = 16;
    localparam int TAG_W   = 8;
    localparam int CU_W    = 8;
    localparam int ADDR_W  = 64;
    localparam int SIZE_W  = 12;

    logic                        clock;
    logic                        rstn;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*SIZE_W-1:0]   req_size;
    logic [NUM_REQ*CU_W-1:0]     req_cu_id;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [TAG_W-1:0]            cmd_tag;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [SIZE_W-1:0]           cmd_size;
    logic [CU_W-1:0]             cmd_cu_id;
    logic                        rsp_valid;
    logic [TAG_W-1:0]            rsp_tag;
    logic                        rsp_cu_valid;
    logic [CU_W-1:0]             rsp_cu_id;
    logic [TAG_W:0]              tags_outstanding;
    logic                        tag_error;

    cmd_tag_arbiter dut (
        .clock            (clock),
        .rstn             (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_cu_id        (req_cu_id),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_tag          (cmd_tag),
        .cmd_addr         (cmd_addr),
        .cmd_size         (cmd_size),
        .cmd_cu_id        (cmd_cu_id),
        .rsp_valid        (rsp_valid),
        .rsp_tag          (rsp_tag),
        .rsp_cu_valid     (rsp_cu_valid),
        .rsp_cu_id        (rsp_cu_id),
        .tags_outstanding (tags_outstanding),
        .tag_error        (tag_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Requester i carries fixed fields keyed by k = i ^ 3, so requester 3
    // presents addr 0x1000, size 128, cu_id 0x05.
    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return 64'h1000 + 64'(i ^ 3) * 64'h10000;
    endfunction
    function automatic logic [SIZE_W-1:0] size_of(input int i);
        return 12'(128 + (i ^ 3));
    endfunction
    function automatic logic [CU_W-1:0] cu_of(input int i);
        return 8'(5 + 16 * (i ^ 3));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] rv, input logic rdy, input logic sv, input logic [7:0] st);
        req_valid = rv;
        cmd_ready = rdy;
        rsp_valid = sv;
        rsp_tag   = st;
    endtask

    task automatic chk_cmd(input string name, input int tag, input int win);
        chk({name, " cmd_valid"}, 64'(cmd_valid), 64'd1);
        chk({name, " cmd_tag"},   64'(cmd_tag),   64'(tag));
        chk({name, " cmd_addr"},  64'(cmd_addr),  64'(addr_of(win)));
        chk({name, " cmd_size"},  64'(cmd_size),  64'(size_of(win)));
        chk({name, " cmd_cu_id"}, 64'(cmd_cu_id), 64'(cu_of(win)));
    endtask

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        logic        sv;
        logic [7:0]  st;
        logic [15:0] exp_ready;
        logic        exp_cv;
        int          exp_tag;
        int          exp_win;
        int          exp_out;
        logic        exp_rcv;
        logic [7:0]  exp_rcu;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] req, input logic rdy, input logic sv,
                                input logic [7:0] st, input logic [15:0] er, input logic cv,
                                input int tag, input int win, input int out, input logic rcv,
                                input logic [7:0] rcu, input logic err);
        vec_t v;
        v.req = req; v.rdy = rdy; v.sv = sv; v.st = st;
        v.exp_ready = er; v.exp_cv = cv; v.exp_tag = tag; v.exp_win = win;
        v.exp_out = out; v.exp_rcv = rcv; v.exp_rcu = rcu; v.exp_err = err;
        return v;
    endfunction

    vec_t vecs [14];

    initial begin
        //             req      rdy   sv    st      ready    cv   tag win out rcv  rcu        err
        vecs[0]  = mk(16'h0000, 1'b1, 1'b0, 8'd0,   16'h0000, 1'b0, 0, 0, 0, 1'b0, 8'd0,      1'b0);
        vecs[1]  = mk(16'h0008, 1'b1, 1'b0, 8'd0,   16'h0008, 1'b1, 1, 3, 1, 1'b0, 8'd0,      1'b0);
        vecs[2]  = mk(16'h0000, 1'b1, 1'b0, 8'd0,   16'h0000, 1'b0, 0, 0, 1, 1'b0, 8'd0,      1'b0);
        vecs[3]  = mk(16'h0000, 1'b1, 1'b1, 8'd1,   16'h0000, 1'b0, 0, 0, 0, 1'b1, 8'h05,     1'b0);
        vecs[4]  = mk(16'h0000, 1'b1, 1'b0, 8'd0,   16'h0000, 1'b0, 0, 0, 0, 1'b0, 8'd0,      1'b0);
        vecs[5]  = mk(16'h0003, 1'b1, 1'b0, 8'd0,   16'h0001, 1'b1, 1, 0, 1, 1'b0, 8'd0,      1'b0);
        vecs[6]  = mk(16'h0003, 1'b1, 1'b0, 8'd0,   16'h0002, 1'b1, 2, 1, 2, 1'b0, 8'd0,      1'b0);
        vecs[7]  = mk(16'h0003, 1'b0, 1'b0, 8'd0,   16'h0000, 1'b1, 2, 1, 2, 1'b0, 8'd0,      1'b0);
        vecs[8]  = mk(16'h0003, 1'b1, 1'b0, 8'd0,   16'h0001, 1'b1, 3, 0, 3, 1'b0, 8'd0,      1'b0);
        vecs[9]  = mk(16'h0000, 1'b1, 1'b1, 8'd0,   16'h0000, 1'b0, 0, 0, 3, 1'b1, 8'd0,      1'b1);
        vecs[10] = mk(16'h0000, 1'b1, 1'b1, 8'd200, 16'h0000, 1'b0, 0, 0, 3, 1'b1, 8'd0,      1'b1);
        vecs[11] = mk(16'h0002, 1'b1, 1'b1, 8'd2,   16'h0002, 1'b1, 4, 1, 3, 1'b1, 8'd37,     1'b1);
        vecs[12] = mk(16'h0000, 1'b1, 1'b1, 8'd2,   16'h0000, 1'b0, 0, 0, 3, 1'b1, 8'd0,      1'b1);
        vecs[13] = mk(16'h0000, 1'b1, 1'b0, 8'd0,   16'h0000, 1'b0, 0, 0, 3, 1'b0, 8'd0,      1'b1);

        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = addr_of(i);
            req_size[i*SIZE_W +: SIZE_W]  = size_of(i);
            req_cu_id[i*CU_W +: CU_W]     = cu_of(i);
        end

        // Reset state
        rstn = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        chk("reset cmd_valid",    64'(cmd_valid),        64'd0);
        chk("reset req_ready",    64'(req_ready),        64'd0);
        chk("reset rsp_cu_valid", 64'(rsp_cu_valid),     64'd0);
        chk("reset tag_error",    64'(tag_error),        64'd0);
        chk("reset cmd_tag",      64'(cmd_tag),          64'd0);
        chk("reset cmd_addr",     64'(cmd_addr),         64'd0);
        chk("reset cmd_size",     64'(cmd_size),         64'd0);
        chk("reset cmd_cu_id",    64'(cmd_cu_id),        64'd0);
        chk("reset rsp_cu_id",    64'(rsp_cu_id),        64'd0);
        chk("reset outstanding",  64'(tags_outstanding), 64'd0);
        rstn = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].req, vecs[v].rdy, vecs[v].sv, vecs[v].st);
            #1;
            chk($sformatf("vec%0d req_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
            tick();
            if (vecs[v].exp_cv) begin
                chk_cmd($sformatf("vec%0d", v), vecs[v].exp_tag, vecs[v].exp_win);
            end else begin
                chk($sformatf("vec%0d cmd_valid", v), 64'(cmd_valid), 64'd0);
            end
            chk($sformatf("vec%0d outstanding", v), 64'(tags_outstanding), 64'(vecs[v].exp_out));
            chk($sformatf("vec%0d rsp_cu_valid", v), 64'(rsp_cu_valid), 64'(vecs[v].exp_rcv));
            if (vecs[v].exp_rcv) begin
                chk($sformatf("vec%0d rsp_cu_id", v), 64'(rsp_cu_id), 64'(vecs[v].exp_rcu));
            end
            chk($sformatf("vec%0d tag_error", v), 64'(tag_error), 64'(vecs[v].exp_err));
        end

        // All requesters active: grants 0..15,0 with tags 1..17
        rstn = 1'b0;
        drive(16'h0000, 1'b1, 1'b0, 8'd0);
        tick();
        rstn = 1'b1;
        drive(16'hFFFF, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 17; k++) begin
            #1;
            chk($sformatf("rr%0d req_ready", k), 64'(req_ready), 64'(16'h1 << (k % 16)));
            tick();
            chk_cmd($sformatf("rr%0d", k), k + 1, k % 16);
        end
        chk("rr outstanding", 64'(tags_outstanding), 64'd17);

        // Backpressure: first command held, nothing granted
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d req_ready", k), 64'(req_ready), 64'd0);
            tick();
            chk_cmd($sformatf("stall%0d", k), 17, 0);
        end
        cmd_ready = 1'b1;
        #1;
        chk("release req_ready", 64'(req_ready), 64'h0002);
        tick();
        chk_cmd("release", 18, 1);
        chk("release outstanding", 64'(tags_outstanding), 64'd18);

        // Pool exhaustion, then a single tag returned
        rstn = 1'b0;
        drive(16'h0000, 1'b1, 1'b0, 8'd0);
        tick();
        rstn = 1'b1;
        drive(16'h0004, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 255; k++) begin
            tick();
            chk($sformatf("fill%0d cmd_tag", k), 64'(cmd_tag), 64'(k + 1));
        end
        chk("full outstanding", 64'(tags_outstanding), 64'd255);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("full%0d req_ready", k), 64'(req_ready), 64'd0);
            tick();
            chk($sformatf("full%0d outstanding", k), 64'(tags_outstanding), 64'd255);
        end
        drive(16'h0004, 1'b1, 1'b1, 8'd7);
        #1;
        chk("free7 req_ready same cycle", 64'(req_ready), 64'd0);
        tick();
        chk("free7 rsp_cu_valid", 64'(rsp_cu_valid), 64'd1);
        chk("free7 rsp_cu_id", 64'(rsp_cu_id), 64'(cu_of(2)));
        chk("free7 outstanding", 64'(tags_outstanding), 64'd254);
        drive(16'h0004, 1'b1, 1'b0, 8'd0);
        #1;
        chk("realloc req_ready", 64'(req_ready), 64'h0004);
        tick();
        chk_cmd("realloc", 7, 2);
        chk("realloc outstanding", 64'(tags_outstanding), 64'd255);
        chk("realloc rsp_cu_valid", 64'(rsp_cu_valid), 64'd0);
        chk("realloc tag_error", 64'(tag_error), 64'd0);

        // Asynchronous reset mid-stream
        drive(16'hFFFF, 1'b1, 1'b0, 8'd0);
        rstn = 1'b0;
        #1;
        chk("async cmd_valid", 64'(cmd_valid), 64'd0);
        chk("async outstanding", 64'(tags_outstanding), 64'd0);
        chk("async req_ready", 64'(req_ready), 64'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("post-reset req_ready", 64'(req_ready), 64'h0001);
        tick();
        chk_cmd("post-reset", 1, 0);
        drive(16'h0000, 1'b1, 1'b1, 8'd100);
        tick();
        chk("stale rsp tag_error", 64'(tag_error), 64'd1);
        chk("stale rsp_cu_valid", 64'(rsp_cu_valid), 64'd1);
        chk("stale rsp_cu_id", 64'(rsp_cu_id), 64'd0);
        chk("stale outstanding", 64'(tags_outstanding), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
